mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single shared instruction/data memory port between the fetch stage and the memory stage of the pipelined processor. It serialises fetch reads and memory-stage loads/stores onto one request/acknowledge memory interface. Memory-stage accesses get priority, with a bound on fetch starvation. It sits between the IF and MEM stages and the unified memory. The decode control unit's MemRead/MemWrite, after pipelining, drive the memory-stage request inputs.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width (one instruction word / one data word)
- MAX_STREAK, 3, consecutive memory-stage grants allowed while fetch waits
- TIMEOUT, 15, busy-cycle limit; used only when ARB_TIMEOUT_EN is defined

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- ms_read  in  1  memory-stage load request
- ms_write  in  1  memory-stage store request
- ms_addr  in  ADDR_W  memory-stage address
- ms_wdata  in  DATA_W  store data
- ms_rdata  out  DATA_W  load data, valid while ms_ack=1
- ms_ack  out  1  one-cycle memory-stage completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  high in BUSY or RESP
- err  out  1  timeout pulse; constant 0 without ARB_TIMEOUT_EN

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any request is pending, pick a winner and register mem_req=1, mem_we, mem_addr, mem_wdata. Go to BUSY. Otherwise stay in IDLE.
- Priority:
  - The memory stage (ms_read|ms_write) wins.
  - Exception: when streak==MAX_STREAK and if_req=1, fetch wins.
- Streak counter (saturating at MAX_STREAK):
  - +1 on a memory-stage grant while if_req=1.
  - Cleared on a fetch grant.
  - Cleared on a memory-stage grant with if_req=0.
- ms_read and ms_write both high: treated as a write; the read is ignored.
- BUSY: hold mem_req and all mem_* outputs stable. On mem_ack:
  - Capture mem_rdata into the winner's rdata register (for reads).
  - Drop mem_req and mem_we.
  - Go to RESP.
- RESP: assert the winner's ack for exactly one cycle; all requests are ignored. Go to IDLE.
- Requester rule: deassert the request the cycle after its ack, or it is taken as a new request.
- mem_ack outside BUSY is ignored.
- Reset values: state IDLE, streak 0, all outputs 0 (including rdata registers and mem_addr).
- Reset mid-transaction: return to IDLE at once; no ack is generated; a late mem_ack is ignored.

## Timing
- Request sampled in IDLE at cycle N; mem_req=1 from N+1.
- mem_ack at cycle M; requester ack and rdata at M+1; IDLE at M+2; next grant's mem_req at M+3.
- Minimum transaction with a zero-wait memory (mem_ack at N+1): 3 cycles.
- if_rdata and ms_rdata hold their last captured value between acks.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A BUSY-cycle counter counts up in BUSY.
  - Reaching TIMEOUT without mem_ack forces mem_req=0, the winner's rdata to all-ones, err=1 for one cycle, and entry to RESP. The ack is issued normally.
- ARB_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely.
  - err tied to 0.

## Test plan
- Single fetch, mem_ack 1 cycle after mem_req, mem_rdata=16'h6500 -> if_ack pulse one cycle later with if_rdata=16'h6500; mem_we=0 throughout.
- Simultaneous if_req and ms_write (addr 16'h0002, data 16'h00AA) -> store granted first with mem_we=1; fetch granted immediately after the store's RESP.
- ms_read held continuously alongside if_req with MAX_STREAK=3 -> grant order MS, MS, MS, IF, MS; streak returns to 0 after the IF grant.
- ms_read=ms_write=1 -> single write transaction, ms_ack once, ms_rdata unchanged.
- rst asserted in BUSY with mem_req=1 -> mem_req=0 and all outputs 0 immediately; mem_ack next cycle produces no ack.
- With ARB_TIMEOUT_EN and TIMEOUT=15, mem_ack never returned -> err pulse after 15 BUSY cycles, ms_ack=1 with ms_rdata=16'hFFFF. Without the macro, no ack is ever generated.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one request/acknowledge memory port between the instruction fetch
// stage and the memory stage of the pipeline.  Memory-stage loads and stores
// normally win.  A streak counter lets fetch through after MAX_STREAK
// back-to-back memory-stage grants so that fetch is never starved.
//
// Each transaction walks IDLE -> BUSY -> RESP -> IDLE:
//   IDLE  pick a winner and register the memory request
//   BUSY  hold the memory request stable until mem_ack
//   RESP  pulse the winner's ack for one cycle while ignoring all requests
//
// Optional feature, enabled by defining ARB_TIMEOUT_EN:
//   BUSY is abandoned after TIMEOUT cycles without mem_ack.  The winner's
//   rdata becomes all-ones, err pulses for one cycle and the ack is still
//   issued.  Without the macro BUSY waits indefinitely and err is tied to 0.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   if_req/if_addr      fetch read request, held until if_ack
//   if_rdata/if_ack     fetched word and its one-cycle completion pulse
//   ms_read/ms_write    memory-stage load/store request (both high = store)
//   ms_addr/ms_wdata    memory-stage address and store data
//   ms_rdata/ms_ack     load data and its one-cycle completion pulse
//   mem_req/mem_we      memory request (held until mem_ack) and write enable
//   mem_addr/mem_wdata  memory address and write data
//   mem_rdata/mem_ack   memory read data and one-cycle completion
//   busy                high while in BUSY or RESP
//   err                 one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ms_read,
  input  logic              ms_write,
  input  logic [ADDR_W-1:0] ms_addr,
  input  logic [DATA_W-1:0] ms_wdata,
  output logic [DATA_W-1:0] ms_rdata,
  output logic              ms_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int StreakW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                msWin_q, msWin_d;
  logic                memReq_q, memReq_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [DATA_W-1:0]   memWdata_q, memWdata_d;
  logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0]   msRdata_q, msRdata_d;
  logic                ifAck_q, ifAck_d;
  logic                msAck_q, msAck_d;

`ifdef ARB_TIMEOUT_EN
  localparam int ToW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  logic [ToW-1:0]      toCnt_q, toCnt_d;
  logic                err_q, err_d;
`endif

  logic msAny;
  logic ifWins;

  // Fetch only beats a pending memory-stage access once the streak of
  // memory-stage grants made while fetch was waiting has saturated.
  assign msAny  = ms_read | ms_write;
  assign ifWins = if_req & (~msAny | (streak_q == StreakMax));

  // Next-state and output-register logic for the three-state sequencer.
  // Every register defaults to holding its value; the ack pulses and err
  // default to 0 so they only last a single cycle.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    msWin_d    = msWin_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ifRdata_d  = ifRdata_q;
    msRdata_d  = msRdata_q;
    ifAck_d    = 1'b0;
    msAck_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    toCnt_d    = toCnt_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (msAny || if_req) begin
          state_d  = BUSY;
          memReq_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          toCnt_d  = '0;
`endif
          if (ifWins) begin
            msWin_d    = 1'b0;
            memWe_d    = 1'b0;
            memAddr_d  = if_addr;
            memWdata_d = '0;
            streak_d   = '0;
          end else begin
            // A simultaneous read and write is served as a plain store.
            msWin_d    = 1'b1;
            memWe_d    = ms_write;
            memAddr_d  = ms_addr;
            memWdata_d = ms_wdata;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != StreakMax) begin
              streak_d = streak_q + 1'b1;
            end
          end
        end
      end

      BUSY: begin
        if (mem_ack) begin
          state_d  = RESP;
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
          ifAck_d  = ~msWin_q;
          msAck_d  = msWin_q;
          if (!memWe_q) begin
            if (msWin_q) begin
              msRdata_d = mem_rdata;
            end else begin
              ifRdata_d = mem_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
        end else if (toCnt_q == ToLast) begin
          // Give up on the memory: the requester still gets its ack, but
          // with all-ones data and a one-cycle err flag alongside it.
          state_d  = RESP;
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
          ifAck_d  = ~msWin_q;
          msAck_d  = msWin_q;
          err_d    = 1'b1;
          if (msWin_q) begin
            msRdata_d = '1;
          end else begin
            ifRdata_d = '1;
          end
        end else begin
          toCnt_d = toCnt_q + 1'b1;
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.  Reset lands in IDLE with every output low,
  // which also abandons an in-flight transaction without acking it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      msWin_q    <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifRdata_q  <= '0;
      msRdata_q  <= '0;
      ifAck_q    <= 1'b0;
      msAck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      msWin_q    <= msWin_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifRdata_q  <= ifRdata_d;
      msRdata_q  <= msRdata_d;
      ifAck_q    <= ifAck_d;
      msAck_q    <= msAck_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // BUSY-cycle counter and the registered timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      toCnt_q <= toCnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign if_rdata  = ifRdata_q;
  assign if_ack    = ifAck_q;
  assign ms_rdata  = msRdata_q;
  assign ms_ack    = msAck_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter with default parameters.  A small
// behavioural memory answers mem_req after a programmable latency.  Each
// scenario task pushes the events it expects (grants seen on the memory
// port, if/ms acks, err pulses, each tagged with its cycle) into a queue
// while driving stimulus; observed events are collected as the DUT produces
// them and popped against the expectations.  Define ARB_TIMEOUT_EN for both
// the DUT and this bench to exercise the timeout feature.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        ms_read;
  logic        ms_write;
  logic [15:0] ms_addr;
  logic [15:0] ms_wdata;
  logic [15:0] ms_rdata;
  logic        ms_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        err;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .ms_read   (ms_read),
    .ms_write  (ms_write),
    .ms_addr   (ms_addr),
    .ms_wdata  (ms_wdata),
    .ms_rdata  (ms_rdata),
    .ms_ack    (ms_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .err       (err)
  );

  // kind: "G" grant (a=addr, b=wdata for stores, c=we), "I" fetch ack,
  // "M" memory-stage ack (a=rdata), "E" err pulse; cyc counts negedges
  // from the one after the stimulus was applied.
  typedef struct packed {
    logic [7:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [7:0]  cyc;
  } ev_t;

  ev_t         expQ[$];
  ev_t         actQ[$];
  int          vecCount = 0;
  int          missCount = 0;
  logic [15:0] memArr [0:255];
  int          memLat = 0;
  bit          memAckEn = 1'b1;
  bit          forceAck = 1'b0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: after memLat extra cycles of mem_req it returns
  // mem_ack for one cycle with data from memArr.  forceAck injects a stray
  // ack regardless of mem_req.  Driven on the falling edge.
  initial begin : responder
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (forceAck) begin
        mem_ack = 1'b1;
      end else if (!mem_req) begin
        cnt = 0;
      end else if (memAckEn) begin
        cnt++;
        if (cnt > memLat) begin
          mem_ack   = 1'b1;
          mem_rdata = memArr[mem_addr[7:0]];
          cnt       = 0;
        end
      end
    end
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ev_t mkEv(input logic [7:0] k, input logic [15:0] a,
                               input logic [15:0] b, input logic c, input int cyc);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    e.c    = c;
    e.cyc  = 8'(cyc);
    return e;
  endfunction

  // Plays the requesters' side: records DUT events into actQ and drops a
  // request once it has received ifHold / msHold acks.  Returns when all
  // requests are gone and the arbiter is idle, or after budget cycles.
  task automatic runUntilIdle(input string name, input int ifHold, input int msHold,
                              input int budget);
    bit prevReq;
    bit done;
    int ifAcks;
    int msAcks;
    prevReq = mem_req;
    done    = 1'b0;
    ifAcks  = 0;
    msAcks  = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (mem_req && !prevReq)
        actQ.push_back(mkEv("G", mem_addr, mem_we ? mem_wdata : 16'h0000, mem_we, c));
      prevReq = mem_req;
      if (err) actQ.push_back(mkEv("E", 16'h0, 16'h0, 1'b0, c));
      if (if_ack) begin
        actQ.push_back(mkEv("I", if_rdata, 16'h0, 1'b0, c));
        ifAcks++;
        if (ifAcks >= ifHold) if_req = 1'b0;
      end
      if (ms_ack) begin
        actQ.push_back(mkEv("M", ms_rdata, 16'h0, 1'b0, c));
        msAcks++;
        if (msAcks >= msHold) begin
          ms_read  = 1'b0;
          ms_write = 1'b0;
        end
      end
      if (!if_req && !ms_read && !ms_write && !busy) done = 1'b1;
    end
    vecCount++;
    if (!done) begin
      missCount++;
      $display("[TB] FAIL %s completion: got still busy after %0d cycles, expected idle", name, budget);
      if_req = 1'b0;
      ms_read = 1'b0;
      ms_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0;  if_addr = 16'h0;
    ms_read = 1'b0; ms_write = 1'b0; ms_addr = 16'h0; ms_wdata = 16'h0;
    repeat (2) @(negedge clk);
    vecCount++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, ms_ack, if_rdata, ms_rdata, busy, err} !== '0) begin
      missCount++;
      $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h iack=%b mack=%b ird=%h mrd=%h busy=%b err=%b, expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, if_ack, ms_ack, if_rdata, ms_rdata, busy, err);
    end
    rst = 1'b0;
    @(negedge clk);
    vecCount++;
    if ({mem_req, busy, if_ack, ms_ack} !== 4'b0000) begin
      missCount++;
      $display("[TB] FAIL reset_release_idle: got req=%b busy=%b iack=%b mack=%b, expected 0000",
               mem_req, busy, if_ack, ms_ack);
    end
  endtask

  task automatic test_single_fetch();
    ev_t e;
    ev_t a;
    memLat  = 1;
    if_addr = 16'h0010;
    if_req  = 1'b1;
    expQ.push_back(mkEv("G", 16'h0010, 16'h0000, 1'b0, 0));
    expQ.push_back(mkEv("I", 16'h6500, 16'h0000, 1'b0, 2));
    runUntilIdle("single_fetch", 1, 1, 20);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = (actQ.size() > 0) ? actQ.pop_front() : '0;
      vecCount++;
      if (a !== e) begin
        missCount++;
        $display("[TB] FAIL single_fetch event: got %h, expected %h", a, e);
      end
    end
    vecCount++;
    if (actQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL single_fetch extra events: got %0d, expected 0", actQ.size());
      actQ.delete();
    end
    repeat (2) @(negedge clk);
    vecCount++;
    if (if_rdata !== 16'h6500) begin
      missCount++;
      $display("[TB] FAIL single_fetch rdata_hold: got %h, expected 6500", if_rdata);
    end
    memLat = 0;
  endtask

  task automatic test_store_then_fetch();
    ev_t e;
    ev_t a;
    if_addr  = 16'h0020;
    ms_addr  = 16'h0002;
    ms_wdata = 16'h00AA;
    if_req   = 1'b1;
    ms_write = 1'b1;
    // The store is acked without touching ms_rdata, still 0 from reset.
    expQ.push_back(mkEv("G", 16'h0002, 16'h00AA, 1'b1, 0));
    expQ.push_back(mkEv("M", 16'h0000, 16'h0000, 1'b0, 1));
    expQ.push_back(mkEv("G", 16'h0020, 16'h0000, 1'b0, 3));
    expQ.push_back(mkEv("I", 16'h1234, 16'h0000, 1'b0, 4));
    runUntilIdle("store_then_fetch", 1, 1, 20);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = (actQ.size() > 0) ? actQ.pop_front() : '0;
      vecCount++;
      if (a !== e) begin
        missCount++;
        $display("[TB] FAIL store_then_fetch event: got %h, expected %h", a, e);
      end
    end
    vecCount++;
    if (actQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL store_then_fetch extra events: got %0d, expected 0", actQ.size());
      actQ.delete();
    end
  endtask

  task automatic test_streak();
    ev_t e;
    ev_t a;
    bit  isIf [9];
    // Both requesters held: fetch gets in after every third memory-stage
    // grant; fetch gives up after its second ack, leaving one last MS.
    isIf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_addr = 16'h0030;
    ms_addr = 16'h0040;
    if_req  = 1'b1;
    ms_read = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (isIf[i]) begin
        expQ.push_back(mkEv("G", 16'h0030, 16'h0000, 1'b0, 3 * i));
        expQ.push_back(mkEv("I", memArr[8'h30], 16'h0000, 1'b0, 3 * i + 1));
      end else begin
        expQ.push_back(mkEv("G", 16'h0040, 16'h0000, 1'b0, 3 * i));
        expQ.push_back(mkEv("M", memArr[8'h40], 16'h0000, 1'b0, 3 * i + 1));
      end
    end
    runUntilIdle("streak", 2, 7, 60);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = (actQ.size() > 0) ? actQ.pop_front() : '0;
      vecCount++;
      if (a !== e) begin
        missCount++;
        $display("[TB] FAIL streak event: got %h, expected %h", a, e);
      end
    end
    vecCount++;
    if (actQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL streak extra events: got %0d, expected 0", actQ.size());
      actQ.delete();
    end
  endtask

  task automatic test_read_write_both();
    ev_t e;
    ev_t a;
    ms_addr  = 16'h0050;
    ms_wdata = 16'h5A5A;
    ms_read  = 1'b1;
    ms_write = 1'b1;
    // Served as a store; ms_rdata keeps the last load result (from 0x0040).
    expQ.push_back(mkEv("G", 16'h0050, 16'h5A5A, 1'b1, 0));
    expQ.push_back(mkEv("M", memArr[8'h40], 16'h0000, 1'b0, 1));
    runUntilIdle("read_write_both", 1, 1, 20);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = (actQ.size() > 0) ? actQ.pop_front() : '0;
      vecCount++;
      if (a !== e) begin
        missCount++;
        $display("[TB] FAIL read_write_both event: got %h, expected %h", a, e);
      end
    end
    vecCount++;
    if (actQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL read_write_both extra events: got %0d, expected 0", actQ.size());
      actQ.delete();
    end
  endtask

  task automatic test_midreset();
    int bad;
    memAckEn = 1'b0;
    ms_addr  = 16'h0060;
    ms_read  = 1'b1;
    repeat (3) @(negedge clk);
    vecCount++;
    if ({mem_req, busy} !== 2'b11) begin
      missCount++;
      $display("[TB] FAIL midreset_busy: got req=%b busy=%b, expected 1 1", mem_req, busy);
    end
    #2;
    rst     = 1'b1;
    ms_read = 1'b0;
    #1;
    vecCount++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, ms_ack, if_rdata, ms_rdata, busy, err} !== '0) begin
      missCount++;
      $display("[TB] FAIL midreset_outputs: got req=%b addr=%h ird=%h mrd=%h busy=%b, expected all 0",
               mem_req, mem_addr, if_rdata, ms_rdata, busy);
    end
    @(negedge clk);
    rst      = 1'b0;
    memAckEn = 1'b1;
    #2;
    forceAck = 1'b1;
    @(negedge clk);
    #2;
    forceAck = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ack || ms_ack || mem_req || busy || err) bad++;
    end
    vecCount++;
    if (bad != 0) begin
      missCount++;
      $display("[TB] FAIL midreset_late_ack: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_timeout();
    int          reqCycles;
    bit          sawErr;
    bit          sawAck;
    logic [15:0] rd;
    reqCycles = 0;
    sawErr    = 1'b0;
    sawAck    = 1'b0;
    rd        = 16'h0000;
    memAckEn  = 1'b0;
    ms_addr   = 16'h0070;
    ms_read   = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (err || ms_ack || if_ack) begin
        sawErr = err;
        sawAck = ms_ack;
        rd     = ms_rdata;
        break;
      end
      if (mem_req) reqCycles++;
    end
`ifdef ARB_TIMEOUT_EN
    vecCount++;
    if (reqCycles != 15) begin
      missCount++;
      $display("[TB] FAIL timeout_busy_cycles: got %0d, expected 15", reqCycles);
    end
    vecCount++;
    if ({sawErr, sawAck} !== 2'b11) begin
      missCount++;
      $display("[TB] FAIL timeout_err_ack: got err=%b ack=%b, expected 1 1", sawErr, sawAck);
    end
    vecCount++;
    if (rd !== 16'hFFFF) begin
      missCount++;
      $display("[TB] FAIL timeout_rdata: got %h, expected ffff", rd);
    end
    ms_read = 1'b0;
    @(negedge clk);
    vecCount++;
    if ({err, ms_ack, busy} !== 3'b000) begin
      missCount++;
      $display("[TB] FAIL timeout_pulse_end: got err=%b ack=%b busy=%b, expected 000", err, ms_ack, busy);
    end
`else
    vecCount++;
    if ({sawErr, sawAck} !== 2'b00) begin
      missCount++;
      $display("[TB] FAIL no_timeout_ack: got err=%b ack=%b, expected 0 0", sawErr, sawAck);
    end
    vecCount++;
    if (reqCycles != 60 || mem_req !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL no_timeout_wait: got %0d req cycles req=%b, expected 60 and 1", reqCycles, mem_req);
    end
    ms_read = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    @(negedge clk);
    vecCount++;
    if ({mem_req, busy} !== 2'b00) begin
      missCount++;
      $display("[TB] FAIL no_timeout_recover: got req=%b busy=%b, expected 0 0", mem_req, busy);
    end
`endif
    memAckEn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 16'(i * 257);
    memArr[8'h10] = 16'h6500;
    memArr[8'h20] = 16'h1234;
    memArr[8'h30] = 16'hC0DE;
    memArr[8'h40] = 16'h4444;
    memArr[8'h50] = 16'h9999;
    memArr[8'h70] = 16'h7777;
    $display("[TB] mem_port_arbiter bench start");
    test_reset();
    test_single_fetch();
    test_store_then_fetch();
    test_streak();
    test_read_write_both();
    test_midreset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
